// File: rtl/enemy_scheduler_if.sv
// rtl/enemy_scheduler_if.sv - game-logic <-> enemy scheduler signal bundle
interface enemy_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic                   enable;
  logic [NUM_SLOTS-1:0]   slot_alive;
  logic [9*NUM_SLOTS-1:0] slot_pos;
  logic [7:0]             player_damage;
  logic [NUM_SLOTS-1:0]   move_scen;
  logic [NUM_SLOTS-1:0]   damage_scen;
  logic [7:0]             damage_out;
  logic [8:0]             front_pos;
  logic [NUM_SLOTS-1:0]   spawn_req;
  logic [1:0]             spawn_type;
  logic [7:0]             wave_count;
  logic                   tick;

  // Scheduler side: reads unit status, drives the per-slot strobes.
  modport master (
    input  enable, slot_alive, slot_pos, player_damage,
    output move_scen, damage_scen, damage_out, front_pos,
           spawn_req, spawn_type, wave_count, tick
  );

  // Game-logic / unit-array side.
  modport slave (
    output enable, slot_alive, slot_pos, player_damage,
    input  move_scen, damage_scen, damage_out, front_pos,
           spawn_req, spawn_type, wave_count, tick
  );
endinterface

// File: rtl/enemy_scheduler.sv
// rtl/enemy_scheduler.sv - per-tick damage/move/spawn sequencer for enemy slots
module enemy_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int TICK_DIV  = 50_000_000,
  parameter int SPAWN_GAP = 4
) (
  input  logic clk,
  input  logic reset,
  enemy_scheduler_if.master bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SPAWN_GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_DAMAGE, S_MOVE, S_SPAWN} state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [SW-1:0]        spawn_cnt;
  logic                 tick_adv;
  logic                 tick_wrap;
  logic                 front_found;
  logic [8:0]           front_best;
  logic [NUM_SLOTS-1:0] front_oh;
  logic                 free_found;
  logic [NUM_SLOTS-1:0] free_oh;
  logic [7:0]           wave_mod;

  // Once a sequence has started the divider keeps running so the tick period
  // stays exactly TICK_DIV; enable only gates it while idle.
  assign tick_adv  = (state != S_IDLE) || bus.enable;
  assign tick_wrap = tick_adv && (tick_cnt == TW'(TICK_DIV - 1));
  assign wave_mod  = bus.wave_count % 8'd3;

  // Front search (largest position, lowest index on ties) and free-slot search.
  always_comb begin
    front_found = 1'b0;
    front_best  = '0;
    front_oh    = '0;
    free_found  = 1'b0;
    free_oh     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (bus.slot_alive[i] && (!front_found || bus.slot_pos[9*i +: 9] > front_best)) begin
        front_found = 1'b1;
        front_best  = bus.slot_pos[9*i +: 9];
        front_oh    = '0;
        front_oh[i] = 1'b1;
      end
      if (!bus.slot_alive[i] && !free_found) begin
        free_found = 1'b1;
        free_oh[i] = 1'b1;
      end
    end
  end

  // Game tick divider and tick pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      bus.tick <= 1'b0;
    end else begin
      bus.tick <= tick_wrap;
      if (tick_wrap) begin
        tick_cnt <= '0;
      end else if (tick_adv) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Registered front position, refreshed every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.front_pos <= '0;
    end else begin
      bus.front_pos <= front_found ? front_best : 9'd0;
    end
  end

  // Phase sequencer with registered strobes: damage, move, spawn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      spawn_cnt       <= '0;
      bus.wave_count  <= '0;
      bus.move_scen   <= '0;
      bus.damage_scen <= '0;
      bus.damage_out  <= '0;
      bus.spawn_req   <= '0;
      bus.spawn_type  <= '0;
    end else begin
      bus.move_scen   <= '0;
      bus.damage_scen <= '0;
      bus.damage_out  <= '0;
      bus.spawn_req   <= '0;
      bus.spawn_type  <= '0;
      case (state)
        S_IDLE: begin
          if (tick_wrap) begin
            state <= S_DAMAGE;
          end
        end
        S_DAMAGE: begin
          if (front_found && (bus.player_damage != 8'd0)) begin
            bus.damage_scen <= front_oh;
            bus.damage_out  <= bus.player_damage;
          end
          state <= S_MOVE;
        end
        S_MOVE: begin
          bus.move_scen <= bus.slot_alive;
          if (spawn_cnt < SW'(SPAWN_GAP)) begin
            spawn_cnt <= spawn_cnt + 1'b1;
          end
          state <= S_SPAWN;
        end
        S_SPAWN: begin
          if (spawn_cnt >= SW'(SPAWN_GAP)) begin
            if (free_found) begin
              bus.spawn_req  <= free_oh;
              bus.spawn_type <= wave_mod[1:0] + 2'd1;
              if (bus.wave_count != 8'hFF) begin
                bus.wave_count <= bus.wave_count + 8'd1;
              end
              spawn_cnt <= '0;
            end else begin
              spawn_cnt <= SW'(SPAWN_GAP);
            end
          end
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_scheduler.sv
// tb/tb_enemy_scheduler.sv - scoreboard bench for enemy_scheduler
module tb_enemy_scheduler;
  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_tick_cyc = 0;
  int   m_cnt = 0;
  int   m_wave = 0;

  typedef struct {
    logic [3:0] dmg;
    logic [7:0] dmg_out;
    logic [3:0] move;
    logic [3:0] spawn;
    logic [1:0] stype;
    logic [7:0] wave;
    logic [8:0] front;
  } exp_t;

  exp_t sb[$];

  enemy_scheduler_if #(.NUM_SLOTS(N)) bus();

  enemy_scheduler #(.NUM_SLOTS(N), .TICK_DIV(DIV), .SPAWN_GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter used for tick spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.tick) seen = 1'b1;
    end
    if (!seen) chk("tick_timeout", 0, 1);
  endtask

  task automatic do_tick(input logic [3:0] alive, input logic [8:0] p0, input logic [8:0] p1,
                         input logic [8:0] p2, input logic [8:0] p3, input logic [7:0] dmg);
    logic [8:0] pos [4];
    logic       found;
    logic [8:0] best;
    logic [3:0] oh;
    logic [3:0] free;
    exp_t       e;
    exp_t       g;
    bit         seen;
    pos[0] = p0; pos[1] = p1; pos[2] = p2; pos[3] = p3;
    bus.slot_alive    = alive;
    bus.slot_pos      = {p3, p2, p1, p0};
    bus.player_damage = dmg;
    found = 1'b0; best = '0; oh = '0; free = '0;
    for (int i = 0; i < N; i++) begin
      if (alive[i] && (!found || pos[i] > best)) begin
        found = 1'b1; best = pos[i]; oh = 4'(1 << i);
      end
      if (!alive[i] && free == 4'd0) free = 4'(1 << i);
    end
    e.dmg     = (found && dmg != 8'd0) ? oh : 4'd0;
    e.dmg_out = (e.dmg != 4'd0) ? dmg : 8'd0;
    e.move    = alive;
    e.spawn   = '0;
    e.stype   = '0;
    if (m_cnt < GAP) m_cnt++;
    if (m_cnt >= GAP && free != 4'd0) begin
      e.spawn = free;
      e.stype = 2'((m_wave % 3) + 1);
      if (m_wave < 255) m_wave++;
      m_cnt = 0;
    end
    e.wave  = 8'(m_wave);
    e.front = found ? best : 9'd0;
    sb.push_back(e);

    wait_tick(seen);
    g = sb.pop_front();
    if (seen) begin
      chk("tick_period", cyc - last_tick_cyc, DIV);
      last_tick_cyc = cyc;
      chk("front_pos", bus.front_pos, g.front);
      @(negedge clk);
      chk("damage_scen", bus.damage_scen, g.dmg);
      chk("damage_out", bus.damage_out, g.dmg_out);
      chk("move_in_damage", bus.move_scen, 0);
      @(negedge clk);
      chk("move_scen", bus.move_scen, g.move);
      chk("damage_in_move", bus.damage_scen, 0);
      @(negedge clk);
      chk("spawn_req", bus.spawn_req, g.spawn);
      chk("spawn_type", bus.spawn_type, g.stype);
      chk("wave_count", bus.wave_count, g.wave);
    end
  endtask

  initial begin
    bit seen;
    int act;
    int n;
    bus.enable        = 1'b0;
    bus.slot_alive    = '0;
    bus.slot_pos      = '0;
    bus.player_damage = '0;
    repeat (3) @(negedge clk);
    chk("rst_front", bus.front_pos, 0);
    chk("rst_wave", bus.wave_count, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_strobes", {bus.move_scen, bus.damage_scen, bus.spawn_req}, 0);
    chk("rst_damage_out", bus.damage_out, 0);
    chk("rst_spawn_type", bus.spawn_type, 0);
    reset = 1'b0;
    bus.enable = 1'b1;
    last_tick_cyc = cyc;

    do_tick(4'b0101, 9'd10, 9'd0, 9'd25, 9'd0, 8'h30);
    do_tick(4'b1010, 9'd0, 9'd40, 9'd0, 9'd40, 8'h05);
    do_tick(4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 8'hFF);
    do_tick(4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 8'h00);
    do_tick(4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 8'h00);
    do_tick(4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 8'h00);
    do_tick(4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 8'h00);
    do_tick(4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 8'h00);
    chk("wave_after_4", bus.wave_count, 4);
    do_tick(4'b1111, 9'd5, 9'd300, 9'd7, 9'd9, 8'h01);
    do_tick(4'b1111, 9'd5, 9'd300, 9'd7, 9'd9, 8'h02);
    do_tick(4'b1011, 9'd5, 9'd300, 9'd0, 9'd301, 8'h03);

    bus.enable = 1'b0;
    act = 0;
    for (int k = 0; k < 5 * DIV; k++) begin
      @(negedge clk);
      if (bus.tick || bus.move_scen != 0 || bus.damage_scen != 0 || bus.spawn_req != 0) act++;
    end
    chk("paused_activity", act, 0);

    bus.enable     = 1'b1;
    bus.slot_alive = 4'b0011;
    bus.slot_pos   = {9'd0, 9'd0, 9'd20, 9'd30};
    wait_tick(seen);
    if (seen) begin
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_move", bus.move_scen, 4'b0011);
      reset = 1'b1;
      #1;
      chk("async_move_drop", bus.move_scen, 0);
      chk("async_wave", bus.wave_count, 0);
      chk("async_front", bus.front_pos, 0);
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        n++;
        if (bus.tick) seen = 1'b1;
      end
      chk("first_tick_after_reset", n, DIV);
      chk("post_reset_wave", bus.wave_count, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
